// File: rtl/data_ram_ws.sv
// Word-organised big-endian data RAM with programmable wait states.
// Optional error port under `DATA_RAM_ERR_EN` (misaligned / out-of-range).
module data_ram_ws #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq
`ifdef DATA_RAM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q;
  logic               fire;
  logic               acc_err;
  logic               wr_en;
  logic               rd_en;
  logic [ADDR_W-1:0]  idx;

  logic [31:0] mem [DEPTH];

  assign idx = addr[ADDR_W+1:2];

`ifdef DATA_RAM_ERR_EN
  logic err_q;

  assign acc_err = (addr[1:0] != 2'b00) ||
                   (addr[31:ADDR_W+2] != '0);
  assign err     = err_q;
`else
  logic unused_addr;

  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign acc_err     = 1'b0;
`endif

  // A write caught by reset at its completing edge is dropped.
  assign wr_en = fire && we && !acc_err && !rst;
  assign rd_en = fire && !we;

  assign stallreq = ce && (state_q != S_DONE);
  assign data_o   = data_q;

  // Next-state logic: count wait cycles, complete on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ce) begin
          if (WAIT_CYCLES == 0) begin
            fire    = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!ce) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte-masked write; sel[3] is the lowest byte address (bits 31:24).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          mem[idx][8*i +: 8] <= data_i[8*i +: 8];
        end
      end
    end
  end

  // Read data register holds until the next completed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 32'h0;
    end else if (rd_en) begin
      data_q <= acc_err ? 32'h0 : mem[idx];
    end
  end

`ifdef DATA_RAM_ERR_EN
  // Error flag is valid only in the DONE cycle of a bad access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fire && acc_err;
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_ws.sv
// Bench for data_ram_ws: two instances (2 and 0 wait states)
// checked against a word-array reference model.
module tb_data_ram_ws;

  logic        clk;
  logic        rst;
  logic        ce_v   [2];
  logic        we_v   [2];
  logic [31:0] addr_v [2];
  logic [3:0]  sel_v  [2];
  logic [31:0] dat_v  [2];
  logic [31:0] dout_v [2];
  logic        stall_v[2];
`ifdef DATA_RAM_ERR_EN
  logic        err_v  [2];
`endif

  int errors;
  int checks;
  int cyc;
  int wc [2];

  logic [31:0] mem_m  [2][1024];
  logic [31:0] dout_m [2];

  data_ram_ws #(.ADDR_W(10), .WAIT_CYCLES(2), .CNT_W(4)) u_ws2 (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce_v[0]),
    .we       (we_v[0]),
    .addr     (addr_v[0]),
    .sel      (sel_v[0]),
    .data_i   (dat_v[0]),
    .data_o   (dout_v[0]),
    .stallreq (stall_v[0])
`ifdef DATA_RAM_ERR_EN
    ,
    .err      (err_v[0])
`endif
  );

  data_ram_ws #(.ADDR_W(10), .WAIT_CYCLES(0), .CNT_W(4)) u_ws0 (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce_v[1]),
    .we       (we_v[1]),
    .addr     (addr_v[1]),
    .sel      (sel_v[1]),
    .data_i   (dat_v[1]),
    .data_o   (dout_v[1]),
    .stallreq (stall_v[1])
`ifdef DATA_RAM_ERR_EN
    ,
    .err      (err_v[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Drive one request and wait for the DONE cycle (stallreq low).
  task automatic do_access(input int d, input logic w,
                           input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] wd,
                           output int stalls, output logic [31:0] rd,
                           output logic er);
    @(negedge clk);
    ce_v[d]   = 1'b1;
    we_v[d]   = w;
    addr_v[d] = a;
    sel_v[d]  = s;
    dat_v[d]  = wd;
    #1;
    stalls = 0;
    while (stall_v[d] && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rd = dout_v[d];
`ifdef DATA_RAM_ERR_EN
    er = err_v[d];
`else
    er = 1'b0;
`endif
    ce_v[d] = 1'b0;
  endtask

  // One access with model update and checks of latency, data and err.
  task automatic op(input int d, input logic w,
                    input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] wd, input string tag,
                    output logic [31:0] rd);
    int          st;
    int          idx;
    logic        er;
    logic        bad;
    logic [31:0] w_new;
    idx = int'(a[11:2]);
    bad = 1'b0;
`ifdef DATA_RAM_ERR_EN
    bad = (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
`endif
    do_access(d, w, a, s, wd, st, rd, er);
    if (!w) begin
      dout_m[d] = bad ? 32'h0 : mem_m[d][idx];
    end else if (!bad) begin
      w_new = mem_m[d][idx];
      if (s[3]) w_new[31:24] = wd[31:24];
      if (s[2]) w_new[23:16] = wd[23:16];
      if (s[1]) w_new[15:8]  = wd[15:8];
      if (s[0]) w_new[7:0]   = wd[7:0];
      mem_m[d][idx] = w_new;
    end
    checks++;
    if (st !== wc[d] + 1) begin
      errors++;
      $display("FAIL %s stall: got %0d want %0d", tag, st, wc[d] + 1);
    end
    checks++;
    if (rd !== dout_m[d]) begin
      errors++;
      $display("FAIL %s data_o: got %h want %h", tag, rd, dout_m[d]);
    end
`ifdef DATA_RAM_ERR_EN
    checks++;
    if (er !== bad) begin
      errors++;
      $display("FAIL %s err: got %b want %b", tag, er, bad);
    end
`else
    if (er) $display("unexpected err level");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ce_v[d] = 0; we_v[d] = 0; addr_v[d] = 0;
      sel_v[d] = 0; dat_v[d] = 0;
      dout_m[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dout_v[d] !== 32'h0 || stall_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out[%0d]: got %h/%b want 0/0",
                 d, dout_v[d], stall_v[d]);
      end
    end
    ce_v[0] = 1'b1;
    #1;
    checks++;
    if (stall_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follows_ce: got %b want 1", stall_v[0]);
    end
    ce_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    op(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, "wr10", rd);
    op(0, 0, 32'h10, 4'h0, 32'h0, "rd10", rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_read: got %h want deadbeef", rd);
    end
    op(0, 1, 32'h10, 4'b0100, 32'h00AA0000, "bytewr", rd);
    op(0, 0, 32'h10, 4'h0, 32'h0, "byterd", rd);
    checks++;
    if (rd !== 32'hDEAABEEF) begin
      errors++;
      $display("FAIL byte_read: got %h want deaabeef", rd);
    end
    op(0, 1, 32'h10, 4'h0, 32'h55555555, "sel0wr", rd);
    op(0, 0, 32'h10, 4'hF, 32'h0, "sel0rd", rd);
    checks++;
    if (rd !== 32'hDEAABEEF) begin
      errors++;
      $display("FAIL sel0_read: got %h want deaabeef", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] expv [2];
    int          dc [2];
    int          nd;
    int          ns;
    op(1, 1, 32'h10, 4'hF, 32'hA5A5_0010, "b2b_w0", rd);
    op(1, 1, 32'h14, 4'hF, 32'h5A5A_0014, "b2b_w1", rd);
    expv[0] = mem_m[1][4];
    expv[1] = mem_m[1][5];
    dc[0] = 0;
    dc[1] = 0;
    @(negedge clk);
    ce_v[1] = 1; we_v[1] = 0; addr_v[1] = 32'h10; sel_v[1] = 4'hF;
    #1;
    nd = 0;
    ns = 0;
    for (int k = 0; k < 12 && nd < 2; k++) begin
      if (stall_v[1]) begin
        ns++;
      end else begin
        dc[nd] = cyc;
        checks++;
        if (dout_v[1] !== expv[nd]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h want %h",
                   nd, dout_v[1], expv[nd]);
        end
        nd++;
        if (nd == 1) addr_v[1] = 32'h14;
        else ce_v[1] = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    ce_v[1] = 1'b0;
    dout_m[1] = expv[1];
    checks++;
    if (nd !== 2 || ns !== 2) begin
      errors++;
      $display("FAIL b2b_count: got done=%0d stall=%0d want 2/2", nd, ns);
    end
    checks++;
    if (dc[1] - dc[0] !== 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 2", dc[1] - dc[0]);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    op(0, 1, 32'h20, 4'hF, 32'h0BADF00D, "rst_pre", rd);
    op(0, 0, 32'h10, 4'hF, 32'h0, "rst_rd", rd);
    @(negedge clk);
    ce_v[0] = 1; we_v[0] = 1; addr_v[0] = 32'h20;
    sel_v[0] = 4'hF; dat_v[0] = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    dout_m[0] = 32'h0;
    dout_m[1] = 32'h0;
    checks++;
    if (dout_v[0] !== 32'h0 || stall_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got %h/%b want 0/1", dout_v[0], stall_v[0]);
    end
    ce_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stall_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_stall: got %b want 0", stall_v[0]);
    end
    op(0, 0, 32'h20, 4'hF, 32'h0, "rst_after", rd);
    checks++;
    if (rd !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL rst_abandon: got %h want 0badf00d", rd);
    end
  endtask

  task automatic test_ce_drop();
    logic [31:0] rd;
    op(0, 1, 32'h30, 4'hF, 32'hCAFEF00D, "drop_pre", rd);
    op(0, 0, 32'h10, 4'hF, 32'h0, "drop_rd", rd);
    @(negedge clk);
    ce_v[0] = 1; we_v[0] = 1; addr_v[0] = 32'h30;
    sel_v[0] = 4'hF; dat_v[0] = 32'h11111111;
    @(negedge clk);
    ce_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dout_v[0] !== dout_m[0] || stall_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold: got %h/%b want %h/0",
               dout_v[0], stall_v[0], dout_m[0]);
    end
    op(0, 0, 32'h30, 4'hF, 32'h0, "drop_after", rd);
  endtask

  task automatic test_addr_edge();
    logic [31:0] rd;
`ifdef DATA_RAM_ERR_EN
    op(0, 1, 32'h0, 4'hF, 32'h00000011, "err_pre", rd);
    op(0, 0, 32'h2, 4'hF, 32'h0, "err_rd", rd);
    op(0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF, "err_wr", rd);
    op(0, 0, 32'h0, 4'hF, 32'h0, "err_chk", rd);
    checks++;
    if (rd !== 32'h00000011) begin
      errors++;
      $display("FAIL err_suppress: got %h want 00000011", rd);
    end
`else
    op(0, 1, 32'h1000, 4'hF, 32'h00000011, "alias_wr", rd);
    op(0, 0, 32'h0, 4'hF, 32'h0, "alias_rd", rd);
    checks++;
    if (rd !== 32'h00000011) begin
      errors++;
      $display("FAIL alias: got %h want 00000011", rd);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        op(d, 1, 32'h100 + 32'(4 * k), 4'hF, $urandom, "rnd_init", rd);
      end
      for (int n = 0; n < 40; n++) begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 7));
`ifndef DATA_RAM_ERR_EN
        a = a | ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 3));
`endif
        op(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
           $urandom, "rnd", rd);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    wc[0]  = 2;
    wc[1]  = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_access();
    test_ce_drop();
    test_addr_edge();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
